// File: rtl/unpack_pkg.sv
// Shared types and width helpers for the word-to-byte unpacking engine.
package unpack_pkg;

  localparam int WORD_W = 16;
  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HI,
    LO,
    FIN
  } state_e;

  function automatic int wordAddrW(input int nWords);
    return (nWords > 1) ? $clog2(nWords) : 1;
  endfunction

  function automatic int byteAddrW(input int nWords);
    return $clog2(2 * nWords);
  endfunction

endpackage

// File: rtl/byte_ram.sv
// Destination byte memory: one synchronous write port, one registered read port.
module byte_ram
  import unpack_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [BYTE_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [BYTE_W-1:0] rdata_o
);

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [BYTE_W-1:0] rdata_q;

  // Storage is deliberately left unreset so a mid-pass reset keeps written bytes.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= mem[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/unpack_fsm.sv
// Unpacks every 16-bit source word into two bytes (high byte first) on an
// op_mode start, with host-side word writes and registered byte reads.
module unpack_fsm
  import unpack_pkg::*;
#(
  parameter int N_WORDS = 16,
  parameter int WA_W    = wordAddrW(N_WORDS),
  parameter int BA_W    = byteAddrW(N_WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] data_wr,
  input  logic              wr_en,
  input  logic [WA_W-1:0]   wr_add,
  input  logic [BA_W-1:0]   rd_add,
  input  logic              op_mode,
  output logic [BYTE_W-1:0] data_out,
  output logic              done,
  output logic              busy
);

  state_e            state_q, state_d;
  logic [WA_W-1:0]   idx_q, idx_d;
  logic [WORD_W-1:0] word_q, word_d;

  logic [WORD_W-1:0] srcMem [N_WORDS];
  logic              srcWe;

  logic              ramWe;
  logic [BA_W-1:0]   ramWaddr;
  logic [BYTE_W-1:0] ramWdata;

  // Host writes only land while idle so a pass works on a frozen source image.
  assign srcWe = wr_en && ((state_q == IDLE) || (state_q == FIN));

  always_ff @(posedge clk) begin
    if (srcWe) begin
      srcMem[wr_add] <= data_wr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    word_d   = word_q;
    ramWe    = 1'b0;
    ramWaddr = {idx_q, 1'b0};
    ramWdata = word_q[WORD_W-1:BYTE_W];

    case (state_q)
      IDLE, FIN: begin
        if (op_mode) begin
          state_d = LOAD;
          idx_d   = '0;
        end
      end
      LOAD: begin
        word_d  = srcMem[idx_q];
        state_d = HI;
      end
      HI: begin
        ramWe   = 1'b1;
        state_d = LO;
      end
      LO: begin
        ramWe    = 1'b1;
        ramWaddr = {idx_q, 1'b1};
        ramWdata = word_q[BYTE_W-1:0];
        // The index only returns to zero through a new start from FIN.
        if (idx_q == WA_W'(N_WORDS - 1)) begin
          state_d = FIN;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = LOAD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy = (state_q == LOAD) || (state_q == HI) || (state_q == LO);
  assign done = (state_q == FIN);

  byte_ram #(
    .DEPTH (2 * N_WORDS),
    .AW    (BA_W)
  ) u_byte_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (ramWe),
    .waddr_i (ramWaddr),
    .wdata_i (ramWdata),
    .raddr_i (rd_add),
    .rdata_o (data_out)
  );

endmodule

// File: tb/tb_unpack_fsm.sv
// Scoreboard bench for unpack_fsm: reads are queued with model-predicted bytes
// and a separate monitor compares data_out one edge after each read address.
module tb_unpack_fsm;

  localparam int NW = 16;
  localparam int NB = 2 * NW;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] data_wr;
  logic        wr_en;
  logic [3:0]  wr_add;
  logic [4:0]  rd_add;
  logic        op_mode;
  logic [7:0]  data_out;
  logic        done;
  logic        busy;

  int nChecks = 0;
  int nFails  = 0;

  logic [15:0] srcModel [NW];
  logic [7:0]  dstModel [NB];

  typedef struct {
    int         addr;
    logic [7:0] exp;
  } rd_t;

  rd_t expQ[$];
  bit  rdPend = 1'b0;

  always #5 clk = ~clk;

  unpack_fsm #(.N_WORDS(NW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_wr  (data_wr),
    .wr_en    (wr_en),
    .wr_add   (wr_add),
    .rd_add   (rd_add),
    .op_mode  (op_mode),
    .data_out (data_out),
    .done     (done),
    .busy     (busy)
  );

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every cycle with a read outstanding, compare the registered byte.
  always @(posedge clk) begin
    if (rdPend) begin
      #1;
      if (expQ.size() == 0) begin
        checkOutput("readQueueUnderflow", 16'(data_out), 16'hDEAD);
      end else begin
        rd_t e;
        e = expQ.pop_front();
        checkOutput($sformatf("readback[%0d]", e.addr), 16'(data_out), 16'(e.exp));
      end
    end
  end

  task automatic applyStimulus(input int addr, input logic [15:0] w);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_add  = addr[3:0];
    data_wr = w;
    srcModel[addr] = w;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Expected destination after a complete pass: byte 2k = high byte of word k.
  function automatic void modelPass();
    for (int k = 0; k < NW; k++) begin
      dstModel[2*k]   = srcModel[k][15:8];
      dstModel[2*k+1] = srcModel[k][7:0];
    end
  endfunction

  task automatic readByte(input int addr);
    @(negedge clk);
    rd_add = addr[4:0];
    expQ.push_back('{addr, dstModel[addr]});
    rdPend = 1'b1;
  endtask

  task automatic readDone();
    @(negedge clk);
    rdPend = 1'b0;
  endtask

  task automatic startPass(input bit holdOp);
    @(negedge clk);
    op_mode = 1'b1;
    @(negedge clk);
    if (!holdOp) op_mode = 1'b0;
    checkOutput("busyAfterStart", 16'(busy), 16'h1);
    checkOutput("doneDropsAfterStart", 16'(done), 16'h0);
  endtask

  task automatic waitDone(input bit injectIgnored);
    int cycles;
    int busyLow;
    cycles  = 0;
    busyLow = 0;
    while (done !== 1'b1 && cycles < 200) begin
      @(posedge clk);
      #1;
      cycles++;
      if (injectIgnored && cycles == 10) begin
        wr_en   = 1'b1;
        wr_add  = 4'd5;
        data_wr = 16'hFFFF;
        op_mode = 1'b1;
      end
      if (injectIgnored && cycles == 11) begin
        wr_en   = 1'b0;
        op_mode = 1'b0;
      end
      if (done !== 1'b1 && busy !== 1'b1) busyLow++;
    end
    checkOutput("passLatency", 16'(cycles), 16'(3 * NW));
    checkOutput("busyHeldThroughPass", 16'(busyLow), 16'h0);
    checkOutput("busyLowAtDone", 16'(busy), 16'h0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int waitCnt;
    rst_n   = 1'b0;
    data_wr = '0;
    wr_en   = 1'b0;
    wr_add  = '0;
    rd_add  = '0;
    op_mode = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("resetDataOut", 16'(data_out), 16'h0);
    checkOutput("resetDone", 16'(done), 16'h0);
    checkOutput("resetBusy", 16'(busy), 16'h0);
    rst_n = 1'b1;

    $display("[TB] directed pass with ignored write/start during busy");
    for (int k = 0; k < NW; k++) begin
      logic [7:0] hi, lo;
      hi = 8'(4 * k + 1);
      lo = 8'(4 * k + 3);
      applyStimulus(k, {hi, lo});
    end
    startPass(1'b0);
    waitDone(1'b1);
    modelPass();
    for (int b = 0; b < NB; b++) readByte(b);
    readDone();

    $display("[TB] back-to-back reads");
    readByte(31);
    readByte(0);
    readByte(17);
    readDone();

    $display("[TB] second pass with A55A");
    for (int k = 0; k < NW; k++) applyStimulus(k, 16'hA55A);
    startPass(1'b0);
    waitDone(1'b0);
    modelPass();
    for (int b = 0; b < NB; b++) readByte(b);
    readDone();

    $display("[TB] level-held op_mode retriggers from FIN");
    for (int k = 0; k < NW; k++) applyStimulus(k, 16'($urandom));
    startPass(1'b1);
    waitDone(1'b0);
    @(posedge clk);
    #1;
    checkOutput("levelRetriggerBusy", 16'(busy), 16'h1);
    checkOutput("levelRetriggerDone", 16'(done), 16'h0);
    op_mode = 1'b0;
    waitDone(1'b0);
    modelPass();
    for (int i = 0; i < NB; i++) readByte(int'($urandom_range(0, NB - 1)));
    readDone();

    $display("[TB] reset in the middle of a pass");
    for (int k = 0; k < NW; k++) applyStimulus(k, 16'($urandom));
    startPass(1'b0);
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("midResetDone", 16'(done), 16'h0);
    checkOutput("midResetBusy", 16'(busy), 16'h0);
    checkOutput("midResetDataOut", 16'(data_out), 16'h0);
    // Byte b is written on edge 3*(b/2)+2+(b%2) after the start edge.
    for (int b = 0; b < NB; b++) begin
      if (3 * (b / 2) + 2 + (b % 2) <= 20) begin
        dstModel[b] = (b % 2 == 0) ? srcModel[b/2][15:8] : srcModel[b/2][7:0];
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int b = 0; b < 16; b++) readByte(b);
    readDone();

    $display("[TB] random passes");
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < NW; k++) applyStimulus(k, 16'($urandom));
      startPass(1'b0);
      waitDone(1'b0);
      modelPass();
      for (int b = 0; b < NB; b++) readByte(b);
      readDone();
    end

    waitCnt = 0;
    while (expQ.size() > 0 && waitCnt < 10) begin
      @(posedge clk);
      waitCnt++;
    end
    checkOutput("readQueueDrained", 16'(expQ.size()), 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
